// File: rtl/ifu_prefetch.sv
// Prefetching instruction fetch unit: keeps up to MAX_OUTSTANDING requests in flight,
// buffers returned instructions with their PCs and hands them to decode in order.
module ifu_prefetch #(
   parameter int unsigned     XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h80000000,
   parameter int unsigned     DEPTH           = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_resp_valid,
   input  logic [XLEN-1:0] mem_resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] inst_mem_q [DEPTH];
   logic [XLEN-1:0] inst_mem_d [DEPTH];
   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [XLEN-1:0] pc_mem_d   [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d, in_flight_q, in_flight_d, drop_cnt_q, drop_cnt_d;
   logic [XLEN-1:0] rq_pc_q [MAX_OUTSTANDING];
   logic [XLEN-1:0] rq_pc_d [MAX_OUTSTANDING];
   logic [QW-1:0]   rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;

   logic            req_fire, fifo_push, fifo_pop;
   logic [CW:0]     credit_used;

   function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
      return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
   endfunction

   // Slots already holding data plus slots reserved by live (non-dropped) requests.
   assign credit_used   = {1'b0, count_q} + {1'b0, in_flight_q} - {1'b0, drop_cnt_q};
   assign mem_req_valid = !rst && !halt && !redirect_valid &&
                          (in_flight_q < CW'(MAX_OUTSTANDING)) &&
                          (credit_used < (CW+1)'(DEPTH));
   assign mem_req_addr  = fetch_pc_q;
   assign req_fire      = mem_req_valid && mem_req_ready;

   assign inst_valid    = !rst && (count_q != '0);
   assign inst          = inst_mem_q[rd_ptr_q];
   assign inst_pc       = pc_mem_q[rd_ptr_q];

   // Responses belonging to a squashed PC stream never enter the buffer.
   assign fifo_push     = mem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
   assign fifo_pop      = inst_valid && inst_ready;

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      inst_mem_d  = inst_mem_q;
      pc_mem_d    = pc_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rq_pc_d     = rq_pc_q;
      rq_wr_d     = rq_wr_q;
      rq_rd_d     = rq_rd_q;
      drop_cnt_d  = drop_cnt_q;
      in_flight_d = in_flight_q + CW'(req_fire) - CW'(mem_resp_valid);
      count_d     = count_q + CW'(fifo_push) - CW'(fifo_pop);

      if (req_fire) begin
         fetch_pc_d       = fetch_pc_q + XLEN'(4);
         rq_pc_d[rq_wr_q] = fetch_pc_q;
         rq_wr_d          = q_next(rq_wr_q);
      end
      if (mem_resp_valid) begin
         rq_rd_d = q_next(rq_rd_q);
         if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (fifo_push) begin
         inst_mem_d[wr_ptr_q] = mem_resp_data;
         pc_mem_d[wr_ptr_q]   = rq_pc_q[rq_rd_q];
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (fifo_pop) rd_ptr_d = rd_ptr_q + PW'(1);

      // Everything still outstanding after this cycle is stale.
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         drop_cnt_d = in_flight_q - CW'(mem_resp_valid);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q  <= RESET_PC;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_flight_q <= '0;
         drop_cnt_q  <= '0;
         rq_wr_q     <= '0;
         rq_rd_q     <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_flight_q <= in_flight_d;
         drop_cnt_q  <= drop_cnt_d;
         rq_wr_q     <= rq_wr_d;
         rq_rd_q     <= rq_rd_d;
      end
   end

   always_ff @(posedge clk) begin
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
      rq_pc_q    <= rq_pc_d;
   end

   a_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
      (fifo_push && !fifo_pop) |-> (count_q < CW'(DEPTH)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: latency/ready-configurable memory model, PC-stream scoreboard,
// a table of traffic scenarios and hand-written corner-case sequences.
module tb_ifu_prefetch;

   localparam logic [31:0] RST_PC = 32'h80000000;

   logic        clk, rst, halt;
   logic        mem_req_valid, mem_req_ready, mem_resp_valid;
   logic [31:0] mem_req_addr, mem_resp_data;
   logic        inst_valid, inst_ready, redirect_valid;
   logic [31:0] inst, inst_pc, redirect_pc;

   ifu_prefetch dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct {
      int lat; int rdy; int irdy; bit redir; logic [31:0] rpc;
      int ncyc; logic [31:0] exp_first; int min_insts;
   } vec_t;

   mreq_t       mem_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] req_log[$];
   int          n_chk = 0, n_fail = 0, cyc = 0, n_consumed = 0;
   int          k_lat = 1, k_rdy = 100, k_irdy = 100;
   bit          k_rst = 1, k_halt = 0, k_redir = 0;
   logic [31:0] k_rpc = '0;
   bit          prev_stall = 0, got_first = 0;
   logic [31:0] prev_addr = '0, first_pc = '0;
   logic        s_rv, s_iv;
   logic [31:0] s_addr;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic refill(input logic [31:0] start);
      logic [31:0] p = start;
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back(p);
         p = p + 32'd4;
      end
      got_first  = 0;
      n_consumed = 0;
   endtask

   // One clock: drive at negedge, sample 1ns later, record handshakes of the coming posedge.
   task automatic cycle();
      mreq_t       m;
      logic [31:0] e;
      @(negedge clk);
      rst = k_rst; halt = k_halt; redirect_valid = k_redir; redirect_pc = k_rpc;
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      if (k_rst) mem_q.delete();
      else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = data_of(mem_q[0].addr);
         void'(mem_q.pop_front());
      end
      mem_req_ready = ($urandom_range(99) < k_rdy);
      inst_ready    = ($urandom_range(99) < k_irdy);
      #1;
      s_rv = mem_req_valid; s_iv = inst_valid; s_addr = mem_req_addr;
      if (k_rst) begin
         check("rst_req_valid", 64'(mem_req_valid), 64'(0));
         check("rst_inst_valid", 64'(inst_valid), 64'(0));
         prev_stall = 0;
      end else begin
         if (prev_stall && !k_halt && !k_redir)
            check("addr_hold", {31'b0, mem_req_valid, mem_req_addr}, {31'b0, 1'b1, prev_addr});
         prev_stall = mem_req_valid && !mem_req_ready;
         prev_addr  = mem_req_addr;
         if (mem_req_valid && mem_req_ready) begin
            m.addr = mem_req_addr; m.due = cyc + k_lat;
            mem_q.push_back(m);
            req_log.push_back(mem_req_addr);
            check("max_outstanding", 64'(mem_q.size() <= 2), 64'(1));
         end
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) check("exp_q_empty", 64'(1), 64'(0));
            else begin
               e = exp_q.pop_front();
               check("inst_pc", 64'(inst_pc), 64'(e));
               check("inst_data", 64'(inst), 64'(data_of(e)));
               if (!got_first) begin first_pc = inst_pc; got_first = 1; end
               n_consumed++;
            end
         end
         if (k_redir) refill(k_rpc);
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic do_reset(input int n);
      k_rst = 1; k_halt = 0; k_redir = 0;
      for (int i = 0; i < n; i++) cycle();
      k_rst = 0;
      refill(RST_PC);
      req_log.delete();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   vec_t vecs[4];
   logic [2:0] iv_seq;
   int halted_reqs;

   initial begin
      vecs[0] = '{lat:1, rdy:100, irdy:100, redir:0, rpc:32'h0,          ncyc:40,  exp_first:RST_PC,        min_insts:38};
      vecs[1] = '{lat:3, rdy:50,  irdy:100, redir:0, rpc:32'h0,          ncyc:200, exp_first:RST_PC,        min_insts:20};
      vecs[2] = '{lat:1, rdy:100, irdy:60,  redir:1, rpc:32'h80000100,   ncyc:80,  exp_first:32'h80000100,  min_insts:10};
      vecs[3] = '{lat:2, rdy:70,  irdy:70,  redir:1, rpc:32'hFFFFFFF8,   ncyc:100, exp_first:32'hFFFFFFF8,  min_insts:10};

      rst = 1; halt = 0; redirect_valid = 0; redirect_pc = '0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0; inst_ready = 0;

      // First instruction visible two cycles after reset release with 1-cycle memory.
      k_lat = 1; k_rdy = 100; k_irdy = 100;
      do_reset(2);
      for (int i = 0; i < 3; i++) begin cycle(); iv_seq[i] = s_iv; end
      check("first_inst_latency", 64'(iv_seq), 64'(3'b100));

      for (int v = 0; v < 4; v++) begin
         k_lat = vecs[v].lat; k_rdy = vecs[v].rdy; k_irdy = vecs[v].irdy;
         do_reset(2);
         for (int c = 0; c < vecs[v].ncyc; c++) begin
            k_redir = vecs[v].redir && (c == 10);
            k_rpc   = vecs[v].rpc;
            cycle();
         end
         k_redir = 0;
         check($sformatf("vec%0d_first_pc", v), 64'(first_pc), 64'(vecs[v].exp_first));
         check($sformatf("vec%0d_min_insts", v), 64'(n_consumed >= vecs[v].min_insts), 64'(1));
      end

      // Backpressure: exactly DEPTH requests, then resume at the following PC.
      k_lat = 1; k_rdy = 100; k_irdy = 0;
      do_reset(2);
      run(12);
      check("bp_req_count", 64'(req_log.size()), 64'(4));
      check("bp_req_valid_low", 64'(s_rv), 64'(0));
      check("bp_inst_valid", 64'(s_iv), 64'(1));
      k_irdy = 100;
      run(12);
      check("bp_drained", 64'(n_consumed >= 4), 64'(1));
      check("bp_resume_addr", 64'(req_log.size() > 4 ? req_log[4] : 32'h0), 64'(32'h80000010));

      // Redirect with two in flight and a response arriving in the same cycle.
      k_lat = 2; k_rdy = 100; k_irdy = 100;
      do_reset(2);
      run(2);
      k_redir = 1; k_rpc = 32'h80000100;
      cycle();
      check("redir_no_req", 64'(s_rv), 64'(0));
      k_redir = 0;
      cycle();
      check("redir_inst_valid_low", 64'(s_iv), 64'(0));
      check("redir_new_req", {31'b0, s_rv, s_addr}, {31'b0, 1'b1, 32'h80000100});
      run(20);
      check("redir_first_pc", 64'(first_pc), 64'(32'h80000100));
      check("redir_progress", 64'(n_consumed > 0), 64'(1));

      // Halt with two in flight: both delivered, no new requests, resume at next PC.
      k_lat = 3; k_rdy = 100; k_irdy = 100;
      do_reset(2);
      run(2);
      k_halt = 1; halted_reqs = 0;
      for (int i = 0; i < 6; i++) begin cycle(); halted_reqs += int'(s_rv); end
      check("halt_no_req", 64'(halted_reqs), 64'(0));
      check("halt_delivered", 64'(n_consumed), 64'(2));
      k_halt = 0;
      cycle();
      check("halt_resume", {31'b0, s_rv, s_addr}, {31'b0, 1'b1, 32'h80000008});

      // Reset in the middle of traffic.
      k_lat = 2; k_rdy = 100; k_irdy = 0;
      do_reset(2);
      run(5);
      do_reset(1);
      k_irdy = 100;
      cycle();
      check("midrst_inst_valid", 64'(s_iv), 64'(0));
      check("midrst_first_req", {31'b0, s_rv, s_addr}, {31'b0, 1'b1, RST_PC});
      run(10);
      check("midrst_first_pc", 64'(first_pc), 64'(RST_PC));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
